// File: rtl/vga_ctrl_pio.sv
// Avalon-MM output port for VGA pipeline control lines: atomic set/clear/toggle
// writes plus a hardware-timed pulse that holds selected bits high for N clocks.
module vga_ctrl_pio #(
    parameter int                     DATA_WIDTH      = 8,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE     = '0,
    parameter int                     PULSE_LEN_W     = 16,
    parameter logic [PULSE_LEN_W-1:0] PULSE_LEN_RESET = PULSE_LEN_W'(16)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic                  read_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  pulse_busy
);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLEAR     = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE    = 3'd3;
    localparam logic [2:0] ADDR_PULSE     = 3'd4;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd5;
    localparam logic [2:0] ADDR_STATUS    = 3'd6;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   mask_q, mask_d;
    logic [PULSE_LEN_W-1:0]  count_q, count_d;
    logic [PULSE_LEN_W-1:0]  len_q, len_d;

    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_bits;
    logic [PULSE_LEN_W-1:0]  wr_len;
    logic [PULSE_LEN_W-1:0]  load_count;
    logic                    pulse_start;
    logic [31:0]             count_ext;
    logic [31:0]             status_word;
    logic                    unused_bits;

    assign wr_en       = chipselect && !write_n;
    assign wr_bits     = writedata[DATA_WIDTH-1:0];
    assign wr_len      = writedata[PULSE_LEN_W-1:0];
    assign pulse_start = wr_en && (address == ADDR_PULSE) && (wr_bits != '0);

    // A zero length is treated as one so a pulse is never lost.
    assign load_count  = (len_q == '0) ? '0 : len_q - PULSE_LEN_W'(1);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= RESET_VALUE;
            mask_q  <= '0;
            count_q <= '0;
            len_q   <= PULSE_LEN_RESET;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic: bus write first, then pulse start or pulse-end clear on top.
    always_comb begin
        // NOTE: hold-current defaults up front keep every path assigned, so no latches.
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        count_d = count_q;
        len_d   = len_q;

        if (wr_en) begin
            case (address)
                ADDR_DATA:      data_d = wr_bits;
                ADDR_SET:       data_d = data_q | wr_bits;
                ADDR_CLEAR:     data_d = data_q & ~wr_bits;
                ADDR_TOGGLE:    data_d = data_q ^ wr_bits;
                ADDR_PULSE_LEN: len_d  = wr_len;
                default:        ;
            endcase
        end

        if (pulse_start) begin
            // Starting or retriggering: widen the mask and reload the full length.
            data_d  = data_d | wr_bits;
            mask_d  = mask_q | wr_bits;
            count_d = load_count;
            state_d = ACTIVE;
        end else if (state_q == ACTIVE) begin
            if (count_q == '0) begin
                data_d  = data_d & ~mask_q;
                mask_d  = '0;
                state_d = IDLE;
            end else begin
                count_d = count_q - PULSE_LEN_W'(1);
            end
        end
    end

    // Output logic
    assign out_port    = data_q;
    assign pulse_busy  = (state_q == ACTIVE);
    assign count_ext   = 32'(count_q);
    assign status_word = {count_ext[15:0], 15'd0, pulse_busy};

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata = 32'(data_q);
            ADDR_PULSE:     readdata = 32'(mask_q);
            ADDR_PULSE_LEN: readdata = 32'(len_q);
            ADDR_STATUS:    readdata = status_word;
            default:        readdata = '0;
        endcase
    end

    // Reads have no side effects; upper write bits and upper count bits are don't-care.
    assign unused_bits = ^{read_n, writedata, count_ext};

endmodule

// File: tb/tb_vga_ctrl_pio.sv
// Self-checking bench for vga_ctrl_pio: directed register/pulse scenarios plus
// randomized bus traffic compared every cycle against a deadline-based model.
module tb_vga_ctrl_pio;

    localparam int         DW = 8;
    localparam logic [7:0] RV = 8'h01;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [DW-1:0] out_port;
    logic        pulse_busy;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    vga_ctrl_pio #(
        .DATA_WIDTH     (DW),
        .RESET_VALUE    (RV),
        .PULSE_LEN_W    (16),
        .PULSE_LEN_RESET(16'd16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .read_n    (read_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .pulse_busy(pulse_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pulse is an absolute deadline cycle, not a countdown.
    logic [7:0]  m_data, m_mask;
    logic [15:0] m_len;
    bit          m_busy;
    longint      m_cyc, m_end;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data <= RV;
            m_mask <= '0;
            m_len  <= 16'd16;
            m_busy <= 1'b0;
            m_end  <= 0;
            m_cyc  <= 0;
        end else begin : model_step
            logic [7:0]  d, mk, wb;
            logic [15:0] ln;
            bit          b;
            longint      e;
            d  = m_data;
            mk = m_mask;
            ln = m_len;
            b  = m_busy;
            e  = m_end;
            wb = writedata[7:0];
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: d = wb;
                    3'd1: d = d | wb;
                    3'd2: d = d & ~wb;
                    3'd3: d = d ^ wb;
                    3'd5: ln = writedata[15:0];
                    default: ;
                endcase
            end
            if (chipselect && !write_n && address == 3'd4 && wb != 8'd0) begin
                d  = d | wb;
                mk = mk | wb;
                b  = 1'b1;
                e  = m_cyc + ((m_len == 16'd0) ? 1 : longint'(m_len));
            end else if (b && m_cyc == e) begin
                d  = d & ~mk;
                mk = '0;
                b  = 1'b0;
            end
            m_data <= d;
            m_mask <= mk;
            m_len  <= ln;
            m_busy <= b;
            m_end  <= e;
            m_cyc  <= m_cyc + 1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        logic [15:0] rem;
        rem = m_busy ? 16'(m_end - m_cyc) : 16'd0;
        case (a)
            3'd0:    return {24'd0, m_data};
            3'd4:    return {24'd0, m_mask};
            3'd5:    return {16'd0, m_len};
            3'd6:    return {rem, 15'd0, m_busy};
            default: return 32'd0;
        endcase
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            #2;
            check("model out_port", 32'(out_port), 32'(m_data));
            check("model pulse_busy", 32'(pulse_busy), 32'(m_busy));
            check("model readdata", readdata, exp_rd(address));
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        #1;
        check(name, readdata, exp);
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    initial begin
        int hi, bz, st, n0, n2, last0, last2, r;

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("reset out_port", 32'(out_port), 32'h01);
        check("reset pulse_busy", 32'(pulse_busy), 32'h0);
        address = 3'd5;
        #1 check("reset PULSE_LEN read", readdata, 32'd16);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        check("released out_port", 32'(out_port), 32'h01);

        // Register writes
        bus_write(3'd0, 32'hA5);
        check("DATA write", 32'(out_port), 32'hA5);
        read_check(3'd0, 32'hA5, "DATA read");
        bus_write(3'd1, 32'h0F);
        check("SET write", 32'(out_port), 32'hAF);
        bus_write(3'd2, 32'hA0);
        check("CLEAR write", 32'(out_port), 32'h0F);
        bus_write(3'd3, 32'hFF);
        check("TOGGLE write", 32'(out_port), 32'hF0);
        bus_write(3'd0, 32'hFFFF_FF3C);
        check("DATA wide write", 32'(out_port), 32'h3C);
        read_check(3'd0, 32'h3C, "DATA wide read");
        read_check(3'd1, 32'h0, "SET read zero");
        read_check(3'd7, 32'h0, "addr7 read zero");

        // Five-cycle pulse on bit 0
        bus_write(3'd5, 32'd5);
        bus_write(3'd0, 32'd0);
        bus_write(3'd4, 32'h01);
        address = 3'd6;
        #1 check("STATUS first pulse cycle", readdata, 32'h0004_0001);
        hi = 0; bz = 0; st = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_port[0]) hi++;
            if (pulse_busy) bz++;
            if (readdata[0]) st++;
            @(negedge clk);
            #1;
        end
        check("pulse len5 bit0 cycles", 32'(hi), 32'd5);
        check("pulse len5 busy cycles", 32'(bz), 32'd5);
        check("pulse len5 STATUS busy cycles", 32'(st), 32'd5);
        check("STATUS after pulse", readdata, 32'h0);
        check("out_port after pulse", 32'(out_port), 32'h0);

        // Zero length gives a one-cycle pulse; zero mask is ignored
        bus_write(3'd5, 32'd0);
        bus_write(3'd4, 32'h02);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_port[1]) hi++;
            @(negedge clk);
        end
        check("pulse len0 bit1 cycles", 32'(hi), 32'd1);
        bus_write(3'd4, 32'h00);
        check("zero-mask pulse out_port", 32'(out_port), 32'h0);
        check("zero-mask pulse busy", 32'(pulse_busy), 32'h0);

        // Retrigger four cycles in, plus a SET of a masked bit mid-pulse
        bus_write(3'd5, 32'd10);
        bus_write(3'd4, 32'h01);
        n0 = 0; n2 = 0; last0 = -1; last2 = -1;
        for (int i = 0; i < 30; i++) begin
            if (out_port[0]) begin n0++; last0 = i; end
            if (out_port[2]) begin n2++; last2 = i; end
            if (i == 3) begin
                address = 3'd4; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0;
            end else if (i == 6) begin
                address = 3'd1; writedata = 32'h01; chipselect = 1'b1; write_n = 1'b0;
            end else begin
                chipselect = 1'b0; write_n = 1'b1;
            end
            @(negedge clk);
        end
        check("retrigger bit0 cycles", 32'(n0), 32'd14);
        check("retrigger bit2 cycles", 32'(n2), 32'd10);
        check("retrigger bit0 last cycle", 32'(last0), 32'd13);
        check("retrigger common end", 32'(last2), 32'(last0));
        check("retrigger out_port after", 32'(out_port), 32'h0);

        // Asynchronous reset in the middle of a pulse
        bus_write(3'd5, 32'd20);
        bus_write(3'd4, 32'h08);
        repeat (3) @(negedge clk);
        check("pre-reset pulse bit3", 32'(out_port), 32'h08);
        #3 reset_n = 1'b0;
        #1;
        check("mid-pulse reset out_port", 32'(out_port), 32'h01);
        check("mid-pulse reset busy", 32'(pulse_busy), 32'h0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no resume out_port", 32'(out_port), 32'h01);
        check("no resume busy", 32'(pulse_busy), 32'h0);
        read_check(3'd5, 32'd16, "PULSE_LEN after reset");

        // Randomized traffic, model-checked every cycle
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            address = 3'($urandom_range(0, 7));
            if (r < 40) begin
                writedata = $urandom;
                if (address == 3'd5) writedata[15:0] = 16'($urandom_range(0, 12));
                if (address == 3'd4 && r < 8) writedata[7:0] = 8'd0;
                chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1;
            end else begin
                chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1; read_n = 1'b0;
            end
            if (n == 1000) begin
                #3 reset_n = 1'b0;
                #4 reset_n = 1'b1;
            end
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        repeat (20) @(negedge clk);
        #3 cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
